// File: rtl/diffuse_light_scheduler.sv
// Issues one diffuse-pipeline operation per enabled light for each accepted hit and sums the returned components.
// Optional DIFFUSE_SAT_EN: clamp each accumulator channel to [0, 1.0] instead of wrapping.
module diffuse_light_scheduler #(
  parameter int MAX_LIGHTS   = 8,
  parameter int IDX_W        = 3,
  parameter int TAG_W        = 16,
  parameter int PIPE_LATENCY = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_valid,
  output logic             hit_ready,
  input  logic [95:0]      hit_diffuse_color,
  input  logic [95:0]      hit_normal,
  input  logic [TAG_W-1:0] hit_tag,
  input  logic             cfg_light_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [95:0]      cfg_light_color,
  input  logic [95:0]      cfg_to_light,
  input  logic             cfg_count_we,
  input  logic [IDX_W:0]   cfg_count,
  output logic             cfg_rejected,
  output logic             pl_new_data,
  output logic [95:0]      pl_hit_matterial_diffuse_color,
  output logic [95:0]      pl_hit_normal,
  output logic [95:0]      pl_light_color,
  output logic [95:0]      pl_to_light,
  input  logic             pl_output_valid,
  input  logic [95:0]      pl_diffuse_component,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [95:0]      out_color,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // once raised, valid and its payload hold until that edge, and ready never waits on valid.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(MAX_LIGHTS);
  localparam int WC_W = $clog2(MAX_LIGHTS + PIPE_LATENCY + 4);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_LIGHTS + PIPE_LATENCY + 2);

  state_t state, state_nx;

  logic [95:0]    tbl_color [MAX_LIGHTS];
  logic [95:0]    tbl_dir   [MAX_LIGHTS];
  logic [IDX_W:0] count_q, run_cnt, issue_idx, ret_cnt;
  logic [95:0]    acc_q;
  // A light write landing on the acceptance cycle is parked here until the hit retires.
  logic             pend_we;
  logic [IDX_W-1:0] pend_idx;
  logic [95:0]      pend_color, pend_dir;
  logic [WC_W-1:0]  wait_cyc;

  logic       ret_ok, last_ret, last_issue;
  logic [95:0] acc_sum;

  function automatic logic [95:0] acc_add(input logic [95:0] a, input logic [95:0] c);
    logic [95:0] r;
    logic [31:0] ac, cc;
`ifdef DIFFUSE_SAT_EN
    logic [32:0] s;
`endif
    r = '0;
    for (int i = 0; i < 3; i++) begin
      ac = a[32*i +: 32];
      cc = c[32*i +: 32];
`ifdef DIFFUSE_SAT_EN
      s = {1'b0, ac} + (cc[31] ? 33'd0 : {1'b0, cc});
      r[32*i +: 32] = (s > 33'h0_0001_0000) ? 32'h0001_0000 : s[31:0];
`else
      r[32*i +: 32] = ac + cc;
`endif
    end
    return r;
  endfunction

  assign ret_ok     = pl_output_valid && (state == S_ISSUE || state == S_WAIT);
  assign last_ret   = ret_ok && (ret_cnt + CNT_ONE == run_cnt);
  assign last_issue = (issue_idx == run_cnt);
  assign acc_sum    = acc_add(acc_q, pl_diffuse_component);
  assign state_dbg  = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (hit_valid) state_nx = (count_q == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_ret) state_nx = S_DONE;
               else if (last_issue) state_nx = S_WAIT;
      S_WAIT:  if (last_ret) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LIGHTS; i++) begin
        tbl_color[i] <= '0;
        tbl_dir[i]   <= '0;
      end
      count_q    <= '0;
      run_cnt    <= '0;
      issue_idx  <= '0;
      ret_cnt    <= '0;
      acc_q      <= '0;
      pend_we    <= 1'b0;
      pend_idx   <= '0;
      pend_color <= '0;
      pend_dir   <= '0;
      hit_ready  <= 1'b1;
      busy       <= 1'b0;
      cfg_rejected <= 1'b0;
      pl_new_data  <= 1'b0;
      pl_hit_matterial_diffuse_color <= '0;
      pl_hit_normal  <= '0;
      pl_light_color <= '0;
      pl_to_light    <= '0;
      out_valid <= 1'b0;
      out_color <= '0;
      out_tag   <= '0;
    end else begin
      hit_ready    <= (state_nx == S_IDLE);
      busy         <= (state_nx != S_IDLE);
      cfg_rejected <= (state != S_IDLE) && (cfg_light_we || cfg_count_we);

      if (state == S_IDLE && cfg_light_we) begin
        if (hit_valid) begin
          pend_we    <= 1'b1;
          pend_idx   <= cfg_idx;
          pend_color <= cfg_light_color;
          pend_dir   <= cfg_to_light;
        end else begin
          tbl_color[cfg_idx] <= cfg_light_color;
          tbl_dir[cfg_idx]   <= cfg_to_light;
        end
      end
      if (state == S_IDLE && cfg_count_we)
        count_q <= (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;

      case (state)
        S_IDLE: if (hit_valid) begin
          out_tag <= hit_tag;
          acc_q   <= '0;
          ret_cnt <= '0;
          run_cnt <= count_q;
          pl_hit_matterial_diffuse_color <= hit_diffuse_color;
          pl_hit_normal <= hit_normal;
          if (count_q == '0) begin
            out_valid <= 1'b1;
            out_color <= '0;
          end else begin
            pl_new_data    <= 1'b1;
            pl_light_color <= tbl_color[0];
            pl_to_light    <= tbl_dir[0];
            issue_idx      <= CNT_ONE;
          end
        end
        S_ISSUE: if (last_issue) begin
          pl_new_data <= 1'b0;
        end else begin
          pl_new_data    <= 1'b1;
          pl_light_color <= tbl_color[issue_idx[IDX_W-1:0]];
          pl_to_light    <= tbl_dir[issue_idx[IDX_W-1:0]];
          issue_idx      <= issue_idx + CNT_ONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          if (pend_we) begin
            tbl_color[pend_idx] <= pend_color;
            tbl_dir[pend_idx]   <= pend_dir;
            pend_we <= 1'b0;
          end
        end
        default: ;
      endcase

      if (ret_ok) begin
        acc_q   <= acc_sum;
        ret_cnt <= ret_cnt + CNT_ONE;
        if (last_ret) begin
          out_valid   <= 1'b1;
          out_color   <= acc_sum;
          pl_new_data <= 1'b0;
        end
      end
    end
  end

  // Cycles spent waiting on the pipeline; a lost result would run this past the bound.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cyc <= '0;
    else if (state == S_IDLE) wait_cyc <= '0;
    else if ((state == S_ISSUE || state == S_WAIT) && wait_cyc != '1) wait_cyc <= wait_cyc + 1'b1;
  end

  a_no_lost_result: assert property (@(posedge clk) disable iff (rst) wait_cyc <= WAIT_MAX);

endmodule

// File: tb/tb_diffuse_light_scheduler.sv
// Directed bench for diffuse_light_scheduler: vector table of hits plus reject, reset and accept-cycle-write sequences.
module tb_diffuse_light_scheduler;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;
  localparam logic [31:0] QTR  = 32'h0000_4000;
  localparam logic [31:0] EIG  = 32'h0000_2000;
  localparam logic [31:0] NONE = 32'hFFFF_0000;

  logic        clk, rst;
  logic        hit_valid, hit_ready;
  logic [95:0] hit_diffuse_color, hit_normal;
  logic [15:0] hit_tag;
  logic        cfg_light_we;
  logic [2:0]  cfg_idx;
  logic [95:0] cfg_light_color, cfg_to_light;
  logic        cfg_count_we;
  logic [3:0]  cfg_count;
  logic        cfg_rejected;
  logic        pl_new_data;
  logic [95:0] pl_hit_matterial_diffuse_color, pl_hit_normal, pl_light_color, pl_to_light;
  logic        pl_output_valid;
  logic [95:0] pl_diffuse_component;
  logic        out_valid, out_ready;
  logic [95:0] out_color;
  logic [15:0] out_tag;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_chk = 0;
  int n_miss = 0;

  diffuse_light_scheduler dut (
    .clk(clk), .rst(rst),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_diffuse_color(hit_diffuse_color), .hit_normal(hit_normal), .hit_tag(hit_tag),
    .cfg_light_we(cfg_light_we), .cfg_idx(cfg_idx),
    .cfg_light_color(cfg_light_color), .cfg_to_light(cfg_to_light),
    .cfg_count_we(cfg_count_we), .cfg_count(cfg_count), .cfg_rejected(cfg_rejected),
    .pl_new_data(pl_new_data),
    .pl_hit_matterial_diffuse_color(pl_hit_matterial_diffuse_color),
    .pl_hit_normal(pl_hit_normal), .pl_light_color(pl_light_color), .pl_to_light(pl_to_light),
    .pl_output_valid(pl_output_valid), .pl_diffuse_component(pl_diffuse_component),
    .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color), .out_tag(out_tag),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Diffuse pipeline model: colour * light * max(0, n.l), fixed 18-cycle latency.
  function automatic logic [95:0] diffuse(input logic [95:0] m, input logic [95:0] n,
                                          input logic [95:0] lc, input logic [95:0] tl);
    longint d, p;
    logic [95:0] r;
    d = 0;
    r = '0;
    for (int i = 0; i < 3; i++)
      d += longint'($signed(n[32*i +: 32])) * longint'($signed(tl[32*i +: 32]));
    d = d >>> 16;
    if (d < 0) d = 0;
    for (int i = 0; i < 3; i++) begin
      p = (longint'($signed(m[32*i +: 32])) * longint'($signed(lc[32*i +: 32]))) >>> 16;
      p = (p * d) >>> 16;
      r[32*i +: 32] = p[31:0];
    end
    return r;
  endfunction

  logic [17:0] pv;
  logic [95:0] pd [18];
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[16:0], pl_new_data};
      pd[0] <= diffuse(pl_hit_matterial_diffuse_color, pl_hit_normal, pl_light_color, pl_to_light);
      for (int i = 1; i < 18; i++) pd[i] <= pd[i-1];
    end
  end
  assign pl_output_valid      = pv[17];
  assign pl_diffuse_component = pd[17];

  function automatic logic [95:0] trip(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    return {r, g, b};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: all start and end just after a falling edge.
  task automatic program_lights(input logic [3:0] cnt, input logic [95:0] lc, input logic [95:0] tl);
    for (int i = 0; i < 8; i++) begin
      cfg_light_we = 1'b1; cfg_idx = 3'(i); cfg_light_color = lc; cfg_to_light = tl;
      @(posedge clk); @(negedge clk);
    end
    cfg_light_we = 1'b0;
    cfg_count_we = 1'b1; cfg_count = cnt;
    @(posedge clk); @(negedge clk);
    cfg_count_we = 1'b0;
  endtask

  task automatic send_hit(input logic [95:0] dif, input logic [95:0] nrm, input logic [15:0] tag);
    for (int g = 0; g < 50 && !hit_ready; g++) @(negedge clk);
    hit_valid = 1'b1; hit_diffuse_color = dif; hit_normal = nrm; hit_tag = tag;
    @(posedge clk); @(negedge clk);
    hit_valid = 1'b0; cfg_light_we = 1'b0; cfg_count_we = 1'b0;
  endtask

  task automatic collect(input int n_exp, input logic [95:0] exp_c, input logic [15:0] exp_tag,
                         input int exp_lat, input logic [95:0] exp_first, input int hold, input int rej_at);
    int k, issues, last_iss, rej_seen;
    logic [95:0] first_lc;
    logic seen;
    k = 1; issues = 0; last_iss = 0; rej_seen = 0; first_lc = '0; seen = 1'b0;
    while (!seen && k <= 60) begin
      if (pl_new_data) begin
        if (issues == 0) first_lc = pl_light_color;
        issues++;
        last_iss = k;
      end
      if (cfg_rejected) rej_seen++;
      if (out_valid) seen = 1'b1;
      else begin
        if (rej_at == k) begin
          cfg_light_we = 1'b1; cfg_idx = 3'd0; cfg_light_color = trip(HALF, HALF, HALF);
          cfg_count_we = 1'b1; cfg_count = 4'd3;
        end else begin
          cfg_light_we = 1'b0; cfg_count_we = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    cfg_light_we = 1'b0; cfg_count_we = 1'b0;
    if (!seen) begin
      check("out_valid_timeout", 96'd0, 96'd1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    check("latency", 96'(k), 96'(exp_lat));
    check("out_color", out_color, exp_c);
    check("out_tag", 96'(out_tag), 96'(exp_tag));
    check("issue_count", 96'(issues), 96'(n_exp));
    check("rejected_pulses", 96'(rej_seen), (rej_at > 0) ? 96'd1 : 96'd0);
    if (n_exp > 0) begin
      check("last_issue_cycle", 96'(last_iss), 96'(n_exp));
      check("first_light", first_lc, exp_first);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 96'(out_valid), 96'd1);
      check("hold_color", out_color, exp_c);
      check("hold_tag", 96'(out_tag), 96'(exp_tag));
      check("hold_hit_ready", 96'(hit_ready), 96'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 96'(out_valid), 96'd0);
    check("release_ready", 96'(hit_ready), 96'd1);
    check("release_busy", 96'(busy), 96'd0);
  endtask

  typedef struct {
    logic        prog;
    logic [3:0]  cnt;
    int          n;
    logic [95:0] lc, tl, dif, nrm;
    logic [15:0] tag;
    logic [95:0] exp_c, exp_sat;
    int          lat, hold, rej_at;
  } vec_t;

  vec_t vt [10];
  logic [95:0] zup, exp_sel;

  initial begin
    zup = trip(32'd0, 32'd0, ONE);
    vt[0] = '{1'b1, 4'd1,  1, trip(ONE,ONE,ONE), zup, trip(HALF,QTR,ONE), zup, 16'h00A5,
              trip(32'h8000,32'h4000,32'h10000), trip(32'h8000,32'h4000,32'h10000), 20, 10, 0};
    vt[1] = '{1'b1, 4'd3,  3, trip(QTR,QTR,QTR), zup, trip(ONE,ONE,ONE), zup, 16'h0001,
              trip(32'hC000,32'hC000,32'hC000), trip(32'hC000,32'hC000,32'hC000), 22, 0, 0};
    vt[2] = '{1'b1, 4'd0,  0, trip(ONE,ONE,ONE), zup, trip(ONE,ONE,ONE), zup, 16'h0BAD,
              96'd0, 96'd0, 1, 0, 0};
    vt[3] = '{1'b1, 4'd5,  5, trip(ONE,ONE,ONE), zup, trip(HALF,HALF,HALF), zup, 16'h1234,
              trip(32'h28000,32'h28000,32'h28000), trip(ONE,ONE,ONE), 24, 0, 0};
    vt[4] = '{1'b1, 4'd12, 8, trip(EIG,EIG,EIG), zup, trip(ONE,ONE,ONE), zup, 16'hFFFF,
              trip(ONE,ONE,ONE), trip(ONE,ONE,ONE), 27, 0, 0};
    vt[5] = '{1'b1, 4'd2,  2, trip(ONE,ONE,ONE), trip(32'd0,32'd0,NONE), trip(ONE,ONE,ONE), zup, 16'h0005,
              96'd0, 96'd0, 21, 0, 0};
    vt[6] = '{1'b1, 4'd2,  2, trip(ONE,ONE,ONE), trip(32'd0,32'd0,HALF), trip(ONE,HALF,QTR), zup, 16'h0006,
              trip(ONE,HALF,QTR), trip(ONE,HALF,QTR), 21, 0, 0};
    vt[7] = '{1'b1, 4'd1,  1, trip(NONE,NONE,NONE), zup, trip(ONE,ONE,ONE), zup, 16'h0007,
              trip(NONE,NONE,NONE), 96'd0, 20, 0, 0};
    vt[8] = '{1'b1, 4'd1,  1, trip(ONE,ONE,ONE), zup, trip(ONE,ONE,ONE), zup, 16'h0008,
              trip(ONE,ONE,ONE), trip(ONE,ONE,ONE), 20, 0, 5};
    vt[9] = '{1'b0, 4'd1,  1, trip(ONE,ONE,ONE), zup, trip(ONE,ONE,ONE), zup, 16'h0009,
              trip(ONE,ONE,ONE), trip(ONE,ONE,ONE), 20, 0, 0};

    rst = 1'b1; hit_valid = 1'b0; hit_diffuse_color = '0; hit_normal = '0; hit_tag = '0;
    cfg_light_we = 1'b0; cfg_idx = '0; cfg_light_color = '0; cfg_to_light = '0;
    cfg_count_we = 1'b0; cfg_count = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_hit_ready", 96'(hit_ready), 96'd1);
    check("reset_busy", 96'(busy), 96'd0);
    check("reset_out_valid", 96'(out_valid), 96'd0);
    check("reset_pl_new_data", 96'(pl_new_data), 96'd0);
    check("reset_cfg_rejected", 96'(cfg_rejected), 96'd0);
    check("reset_out_color", out_color, 96'd0);
    check("reset_state", 96'(state_dbg), 96'd0);

    for (int i = 0; i < 10; i++) begin
`ifdef DIFFUSE_SAT_EN
      exp_sel = vt[i].exp_sat;
`else
      exp_sel = vt[i].exp_c;
`endif
      if (vt[i].prog) program_lights(vt[i].cnt, vt[i].lc, vt[i].tl);
      send_hit(vt[i].dif, vt[i].nrm, vt[i].tag);
      collect(vt[i].n, exp_sel, vt[i].tag, vt[i].lat, vt[i].lc, vt[i].hold, vt[i].rej_at);
    end

    // Reset while waiting on the pipeline.
    program_lights(4'd1, trip(ONE,ONE,ONE), zup);
    send_hit(trip(ONE,ONE,ONE), zup, 16'h00D1);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 96'(busy), 96'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 96'(busy), 96'd0);
    check("midrst_out_valid", 96'(out_valid), 96'd0);
    check("midrst_hit_ready", 96'(hit_ready), 96'd1);
    check("midrst_pl_new_data", 96'(pl_new_data), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (out_valid || pl_output_valid) stray++;
      end
      check("no_stray_after_reset", 96'(stray), 96'd0);
    end

    // Config write on the acceptance cycle applies to the following hit only.
    program_lights(4'd1, trip(ONE,ONE,ONE), zup);
    cfg_light_we = 1'b1; cfg_idx = 3'd0; cfg_light_color = trip(QTR,QTR,QTR); cfg_to_light = zup;
    cfg_count_we = 1'b1; cfg_count = 4'd2;
    send_hit(trip(ONE,ONE,ONE), zup, 16'h00E1);
    collect(1, trip(ONE,ONE,ONE), 16'h00E1, 20, trip(ONE,ONE,ONE), 0, 0);
    send_hit(trip(ONE,ONE,ONE), zup, 16'h00E2);
`ifdef DIFFUSE_SAT_EN
    collect(2, trip(ONE,ONE,ONE), 16'h00E2, 21, trip(QTR,QTR,QTR), 0, 0);
`else
    collect(2, trip(32'h14000,32'h14000,32'h14000), 16'h00E2, 21, trip(QTR,QTR,QTR), 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end

endmodule

// File: doc/diffuse_light_scheduler.md
Name: diffuse_light_scheduler

Overview:
- Sequences the per-hit diffuse lighting pipeline (18-cycle, new_data/output_valid, no backpressure) over a programmable table of directional lights.
- For each accepted hit it issues one pipeline operation per enabled light, back-to-back, and accumulates the returned diffuse components per channel.
- Emits the summed diffuse colour with the hit tag over a valid/ready handshake.
- Sits between the intersection stage and the shading combiner.

Parameters:
- MAX_LIGHTS, 8, light table depth.
- IDX_W, 3, log2(MAX_LIGHTS), width of the light index.
- TAG_W, 16, width of the opaque hit tag carried with each result.
- PIPE_LATENCY, 18, cycles from pl_new_data to pl_output_valid; used only for bench checks and assertions.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- hit_valid  in  1  hit request present.
- hit_ready  out  1  scheduler can accept a hit.
- hit_diffuse_color  in  96  material diffuse colour; {r,g,b}, signed Q16.16 each, r in [95:64].
- hit_normal  in  96  unit surface normal, same layout.
- hit_tag  in  TAG_W  opaque tag returned with the result.
- cfg_light_we  in  1  write light table entry cfg_idx.
- cfg_idx  in  IDX_W  table index.
- cfg_light_color  in  96  light colour.
- cfg_to_light  in  96  unit direction towards the light.
- cfg_count_we  in  1  write the active light count.
- cfg_count  in  IDX_W+1  number of active lights (0..MAX_LIGHTS).
- cfg_rejected  out  1  one-cycle pulse: a config write was dropped while busy.
- pl_new_data  out  1  issue strobe to the diffuse pipeline.
- pl_hit_matterial_diffuse_color, pl_hit_normal, pl_light_color, pl_to_light  out  96 each  pipeline operands.
- pl_output_valid  in  1  pipeline result strobe.
- pl_diffuse_component  in  96  pipeline result.
- out_valid  out  1  accumulated colour available.
- out_ready  in  1  consumer accepts the result.
- out_color  out  96  summed diffuse colour.
- out_tag  out  TAG_W  tag of the hit.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 except hit_ready=1. Light table, count register, accumulators and counters clear to 0.
- All outputs are registered.
- States and transitions:
  - IDLE: hit_ready=1. On hit_valid, latch the operands and tag, clear the accumulators, set issue_idx=0 and ret_cnt=0. If count==0, go to DONE with out_color=0; otherwise go to ISSUE.
  - ISSUE: each cycle, drive pl_new_data=1 with table[issue_idx] and the latched hit operands, then increment issue_idx. After issuing entry count-1, go to WAIT.
  - WAIT: pl_new_data=0. Go to DONE on the cycle the count-th result is accumulated.
  - DONE: out_valid=1 with out_color and out_tag held stable until out_ready is sampled high. On that edge, clear out_valid and return to IDLE. A new hit is accepted no earlier than the next cycle.
- Accumulation: pl_output_valid is honoured in ISSUE or WAIT (results may arrive while issuing). On each honoured strobe, each channel does acc += component independently (32-bit) and ret_cnt increments.
- pl_output_valid in IDLE or DONE is ignored.
- Latency (hit accepted at edge T, N=count>=1): pl_new_data high for cycles T+1..T+N. out_valid rises at T+N+PIPE_LATENCY+1. The scheduler counts returns and never uses a timer.
- Config writes:
  - Accepted only in IDLE.
  - In any other state they are dropped and cfg_rejected pulses for one cycle.
  - cfg_count > MAX_LIGHTS is stored as MAX_LIGHTS.
  - cfg_light_we and cfg_count_we in the same IDLE cycle both take effect.
  - A write in the same cycle as a hit acceptance takes effect for the next hit, not the current one.
- Reset mid-operation: the FSM returns to IDLE, pl_new_data and out_valid drop immediately, and the partial sum is discarded. The pipeline shares rst, so no stray results are returned.

Optional Feature:
- Macro: DIFFUSE_SAT_EN.
- When defined, each accumulator channel saturates: the sum is clamped to [0, 0x0001_0000] (1.0), and a negative result component is treated as 0.
- When undefined, accumulation is plain 32-bit two's-complement wrap-around addition.

Test Plan:
- Program count=1, light0 colour {1.0,1.0,1.0}, to_light {0,0,1.0}. Hit diffuse {0.5,0.25,1.0}, normal {0,0,1.0}, tag 0x00A5, accepted at T -> pl_new_data high only at T+1; out_valid at T+20 with out_color {0x8000,0x4000,0x10000} and out_tag 0x00A5.
- Program count=3 with three identical lights of colour {0.25,0.25,0.25} along the normal. Hit diffuse {1.0,1.0,1.0} -> three consecutive pl_new_data cycles; out_color {0xC000,0xC000,0xC000} at T+22.
- Program count=0; send a hit -> out_valid at T+1 with out_color=0 and no pl_new_data.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_color and out_tag stable and hit_ready=0; on out_ready=1, IDLE the next cycle.
- Issue cfg_light_we while busy -> cfg_rejected pulses once; table unchanged, verified by the next hit's pl_light_color. Assert rst during WAIT -> busy=0 and out_valid=0 immediately, hit_ready=1.
- Program 5 lights of colour {1.0,1.0,1.0} along the normal. Hit diffuse {0.5,0.5,0.5} -> out_color each channel 0x10000 with DIFFUSE_SAT_EN, 0x28000 without.
